mux_scan_sequencer: RTL and testbench

- Upstream/downstream companion to the 4:1 multiplexer, and the next stage in the DSD lab datapath.
- Drives the mux select lines through every input in order and waits a settle interval at each.
- Samples the mux output Y back in and assembles the captured bits into one parallel word.
- Turns the combinational mux into a timed scan: one start pulse in, one complete snapshot of all mux inputs out, plus a done flag.

---
 rtl/mux_scan_sequencer_if.sv | 35 +++
 rtl/mux_scan_sequencer.sv | 105 ++++++++++
 tb/tb_mux_scan_sequencer.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/mux_scan_sequencer_if.sv
// Signal bundle between the scan sequencer (slave side) and the mux/controller
// environment that drives start/cont/y_in and consumes the captured word.
interface mux_scan_sequencer_if #(
   parameter int SEL_W = 2
);
   localparam int N = 2 ** SEL_W;

   logic             start;
   logic             cont;
   logic             y_in;
   logic [SEL_W-1:0] sel;
   logic [N-1:0]     data_out;
   logic             busy;
   logic             done;

   modport master (
      output start,
      output cont,
      output y_in,
      input  sel,
      input  data_out,
      input  busy,
      input  done
   );

   modport slave (
      input  start,
      input  cont,
      input  y_in,
      output sel,
      output data_out,
      output busy,
      output done
   );
endinterface

// File: rtl/mux_scan_sequencer.sv
// Steps a mux select through all N inputs, holds each for SETTLE_CYCLES before
// sampling y_in, and publishes the complete snapshot with a one-cycle done pulse.
module mux_scan_sequencer #(
   parameter int SEL_W         = 2,
   parameter int SETTLE_CYCLES = 2
) (
   input  logic                clk,
   input  logic                rst,
   mux_scan_sequencer_if.slave bus
);
   localparam int               N           = 2 ** SEL_W;
   localparam logic [7:0]       SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
   localparam logic [SEL_W-1:0] SEL_LAST    = SEL_W'(N - 1);

   typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_e;

   state_e           state_q, state_d;
   logic [7:0]       cnt_q, cnt_d;
   logic [SEL_W-1:0] sel_q, sel_d;
   logic [N-1:0]     shadow_q, shadow_d;
   logic [N-1:0]     data_q, data_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             launch;

   // NOTE: sequential state uses non-blocking assignments so every flop samples
   // the pre-edge values computed by the combinational processes.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (bus.start) state_d = SETTLE;
         SETTLE:  if (cnt_q == SETTLE_LAST) state_d = SAMPLE;
         SAMPLE:  state_d = (sel_q == SEL_LAST) ? DONE : SETTLE;
         DONE:    state_d = bus.cont ? SETTLE : IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      // NOTE: every signal written here gets a default first, otherwise the
      // paths that leave it untouched would infer a latch.
      cnt_d    = cnt_q;
      sel_d    = sel_q;
      shadow_d = shadow_q;
      data_d   = data_q;
      launch   = ((state_q == IDLE) && bus.start) || ((state_q == DONE) && bus.cont);

      if (launch) begin
         cnt_d    = '0;
         sel_d    = '0;
         shadow_d = '0;
      end else begin
         case (state_q)
            SETTLE: cnt_d = cnt_q + 8'd1;
            SAMPLE: begin
               shadow_d[sel_q] = bus.y_in;
               // Last slot: publish with the final bit merged on the same edge.
               if (sel_q == SEL_LAST) begin
                  data_d = shadow_d;
               end else begin
                  sel_d = sel_q + 1'b1;
                  cnt_d = '0;
               end
            end
            default: ;
         endcase
      end

      busy_d = (state_d == SETTLE) || (state_d == SAMPLE);
      done_d = (state_d == DONE);
   end

   // NOTE: the shadow word is a plain register, not a memory array, so it is
   // cleared by reset like any other flop.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q    <= '0;
         sel_q    <= '0;
         shadow_q <= '0;
         data_q   <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         cnt_q    <= cnt_d;
         sel_q    <= sel_d;
         shadow_q <= shadow_d;
         data_q   <= data_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
      end
   end

   assign bus.sel      = sel_q;
   assign bus.data_out = data_q;
   assign bus.busy     = busy_q;
   assign bus.done     = done_q;
endmodule

// File: tb/tb_mux_scan_sequencer.sv
// Directed bench: a 4:1 mux model feeds y_in from a per-test input word I.
module tb_mux_scan_sequencer;
   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] mux_a;
   logic [3:0] mux_b;
   logic       glitch;
   int         n_checks = 0;
   int         n_errors = 0;

   always #5 clk = ~clk;

   mux_scan_sequencer_if #(.SEL_W(2)) bus_a ();
   mux_scan_sequencer_if #(.SEL_W(2)) bus_b ();

   assign bus_a.y_in = mux_a[bus_a.sel] ^ glitch;
   assign bus_b.y_in = mux_b[bus_b.sel];

   mux_scan_sequencer #(.SEL_W(2), .SETTLE_CYCLES(2)) dut_a (
      .clk (clk),
      .rst (rst),
      .bus (bus_a)
   );

   mux_scan_sequencer #(.SEL_W(2), .SETTLE_CYCLES(1)) dut_b (
      .clk (clk),
      .rst (rst),
      .bus (bus_b)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One full scan on dut_a. mode 0: plain, 1: y_in glitches in SETTLE cycles,
   // 2: start toggled while busy.
   task automatic scan_a(input string tag, input logic [3:0] word, input int mode);
      mux_a = word;
      bus_a.start = 1'b1;
      tick();
      for (int c = 0; c < 12; c++) begin
         bus_a.start = (mode == 2 && c < 10) ? c[0] : 1'b0;
         glitch = (mode == 1 && (c % 3) != 2);
         check($sformatf("%s sel c%0d", tag, c), bus_a.sel, c / 3);
         check($sformatf("%s busy c%0d", tag, c), bus_a.busy, 1);
         check($sformatf("%s done c%0d", tag, c), bus_a.done, 0);
         tick();
      end
      glitch = 1'b0;
      check({tag, " done@12"}, bus_a.done, 1);
      check({tag, " busy@12"}, bus_a.busy, 0);
      check({tag, " data"}, bus_a.data_out, word);
      tick();
      check({tag, " done@13"}, bus_a.done, 0);
      check({tag, " busy@13"}, bus_a.busy, 0);
      check({tag, " data hold"}, bus_a.data_out, word);
   endtask

   initial begin
      rst = 1'b1;
      glitch = 1'b0;
      mux_a = 4'b0000;
      mux_b = 4'b0000;
      bus_a.start = 1'b0;
      bus_a.cont = 1'b0;
      bus_b.start = 1'b0;
      bus_b.cont = 1'b0;
      tick();
      tick();
      check("rst sel", bus_a.sel, 0);
      check("rst data", bus_a.data_out, 0);
      check("rst busy", bus_a.busy, 0);
      check("rst done", bus_a.done, 0);
      check("rst b data", bus_b.data_out, 0);
      check("rst b busy", bus_b.busy, 0);
      rst = 1'b0;
      tick();

      scan_a("basic", 4'b1010, 0);
      scan_a("glitch", 4'b0101, 1);
      scan_a("spam", 4'b0011, 2);

      // Continuous mode; I changes after edge 20, between the sel1 and sel2 samples.
      mux_a = 4'b0110;
      bus_a.cont = 1'b1;
      bus_a.start = 1'b1;
      tick();
      bus_a.start = 1'b0;
      for (int e = 1; e <= 39; e++) begin
         tick();
         check($sformatf("cont done e%0d", e), bus_a.done, (e == 12 || e == 25 || e == 38));
         if (e == 12) check("cont data scan1", bus_a.data_out, 4'b0110);
         if (e == 20) begin
            check("cont data hold", bus_a.data_out, 4'b0110);
            mux_a = 4'b1001;
         end
         if (e == 25) check("cont data mixed", bus_a.data_out, 4'b1010);
         if (e == 27) bus_a.cont = 1'b0;
         if (e == 38) check("cont data scan3", bus_a.data_out, 4'b1001);
      end
      check("cont idle busy", bus_a.busy, 0);

      // Reset in the middle of a scan.
      mux_a = 4'b1111;
      bus_a.start = 1'b1;
      tick();
      bus_a.start = 1'b0;
      repeat (7) tick();
      check("pre-rst busy", bus_a.busy, 1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("midrst sel", bus_a.sel, 0);
      check("midrst busy", bus_a.busy, 0);
      check("midrst data", bus_a.data_out, 0);
      check("midrst done", bus_a.done, 0);
      for (int c = 0; c < 14; c++) begin
         tick();
         check($sformatf("post-rst quiet c%0d", c), {bus_a.busy, bus_a.done}, 2'b00);
      end
      scan_a("rescan", 4'b1111, 0);

      // SETTLE_CYCLES=1 instance: two-cycle slots, done after edge 8.
      mux_b = 4'b1100;
      bus_b.start = 1'b1;
      tick();
      bus_b.start = 1'b0;
      for (int c = 0; c < 8; c++) begin
         check($sformatf("s1 sel c%0d", c), bus_b.sel, c / 2);
         check($sformatf("s1 busy c%0d", c), bus_b.busy, 1);
         check($sformatf("s1 done c%0d", c), bus_b.done, 0);
         tick();
      end
      check("s1 done@8", bus_b.done, 1);
      check("s1 busy@8", bus_b.busy, 0);
      check("s1 data", bus_b.data_out, 4'b1100);
      tick();
      check("s1 done@9", bus_b.done, 0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule
